// File: rtl/calib_pattern_gen.sv
// rtl/calib_pattern_gen.sv - streams one address-bit calibration frame, then waits for strip latch and settle.
module calib_pattern_gen #(
  parameter int          NUM_LEDS               = 50,
  parameter int          LED_ADDRESS_WIDTH      = $clog2(NUM_LEDS),
  parameter int          LED_ADDR_BIT_SEL_WIDTH = (LED_ADDRESS_WIDTH > 1) ? $clog2(LED_ADDRESS_WIDTH) : 1,
  parameter logic [23:0] ON_COLOR               = 24'hFFFFFF,
  parameter int          SETTLE_CYCLES          = 500_000
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [LED_ADDR_BIT_SEL_WIDTH-1:0] led_addr_bit_sel_in,
  input  logic                              led_addr_bit_sel_start_in,
  output logic [23:0]                       color_out,
  output logic [LED_ADDRESS_WIDTH-1:0]      led_index_out,
  output logic                              color_valid_out,
  output logic                              color_first_out,
  output logic                              color_last_out,
  input  logic                              color_ready_in,
  input  logic                              strip_latched_in,
  output logic                              led_display_valid_out,
  output logic                              busy_out
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] STREAM     = 2'd1;
  localparam logic [1:0] WAIT_LATCH = 2'd2;
  localparam logic [1:0] SETTLE     = 2'd3;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [LED_ADDRESS_WIDTH-1:0] LAST_IDX    = LED_ADDRESS_WIDTH'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0]             SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [LED_ADDRESS_WIDTH-1:0] IDX_ONE     = LED_ADDRESS_WIDTH'(1);

  logic [1:0]                        state_q, state_d;
  logic [LED_ADDR_BIT_SEL_WIDTH-1:0] sel_q, sel_d;
  logic [LED_ADDRESS_WIDTH-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [23:0]                       color_q, color_d;
  logic                              pulse_q, pulse_d;
  logic                              lit;

  // The pulse is decided one cycle ahead so a start in the deciding cycle can still cancel it.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (led_addr_bit_sel_start_in) begin
      state_d = STREAM;
      sel_d   = led_addr_bit_sel_in;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        STREAM: begin
          if (color_ready_in) begin
            if (idx_q == LAST_IDX) begin
              state_d = WAIT_LATCH;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end
        end
        WAIT_LATCH: begin
          if (strip_latched_in) begin
            state_d = SETTLE;
            cnt_d   = SETTLE_LOAD;
            pulse_d = (SETTLE_CYCLES == 0);
          end
        end
        SETTLE: begin
          if (pulse_q) begin
            state_d = IDLE;
          end else if (cnt_q == '0) begin
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // A select beyond the index width shifts the mask out entirely, leaving the strip dark.
  always_comb begin
    lit     = |(idx_d & (IDX_ONE << sel_d));
    color_d = (state_d == STREAM && lit) ? ON_COLOR : 24'h000000;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      color_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      pulse_q <= pulse_d;
    end
  end

  assign color_out             = color_q;
  assign led_index_out         = idx_q;
  assign color_valid_out       = (state_q == STREAM);
  assign color_first_out       = (state_q == STREAM) && (idx_q == '0);
  assign color_last_out        = (state_q == STREAM) && (idx_q == LAST_IDX);
  assign led_display_valid_out = pulse_q;
  assign busy_out              = (state_q != IDLE);

endmodule

// File: tb/tb_calib_pattern_gen.sv
// tb/tb_calib_pattern_gen.sv - two instances (settle 3 and 0) checked each cycle against a frame-level model.
module tb_calib_pattern_gen;

  localparam int          N  = 8;
  localparam int          AW = 3;
  localparam int          SW = 2;
  localparam logic [23:0] ON = 24'hFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, ready, latch;
  logic [SW-1:0] sel;
  logic [23:0]   color_o [2];
  logic [AW-1:0] idx_o   [2];
  logic          valid_o [2];
  logic          first_o [2];
  logic          last_o  [2];
  logic          disp_o  [2];
  logic          busy_o  [2];

  calib_pattern_gen #(.NUM_LEDS(N), .ON_COLOR(ON), .SETTLE_CYCLES(3)) dut0 (
    .clk_in(clk), .rst_in(rst), .led_addr_bit_sel_in(sel), .led_addr_bit_sel_start_in(start),
    .color_out(color_o[0]), .led_index_out(idx_o[0]), .color_valid_out(valid_o[0]),
    .color_first_out(first_o[0]), .color_last_out(last_o[0]), .color_ready_in(ready),
    .strip_latched_in(latch), .led_display_valid_out(disp_o[0]), .busy_out(busy_o[0]));

  calib_pattern_gen #(.NUM_LEDS(N), .ON_COLOR(ON), .SETTLE_CYCLES(0)) dut1 (
    .clk_in(clk), .rst_in(rst), .led_addr_bit_sel_in(sel), .led_addr_bit_sel_start_in(start),
    .color_out(color_o[1]), .led_index_out(idx_o[1]), .color_valid_out(valid_o[1]),
    .color_first_out(first_o[1]), .color_last_out(last_o[1]), .color_ready_in(ready),
    .strip_latched_in(latch), .led_display_valid_out(disp_o[1]), .busy_out(busy_o[1]));

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  bit     prev_rst = 1'b1;

  // Frame-level model: whether a frame is streaming, beats delivered, and the absolute pulse cycle.
  int     settle     [2] = '{3, 0};
  bit     m_stream   [2] = '{0, 0};
  bit     m_wait     [2] = '{0, 0};
  int     m_idx      [2] = '{0, 0};
  int     m_sel      [2] = '{0, 0};
  longint m_pulse_at [2] = '{-1, -1};

  int          disp_cnt  [2] = '{0, 0};
  longint      last_disp [2] = '{-1, -1};
  bit          cap_en = 1'b1;
  logic [23:0] cap_col[$];
  int          cap_idx[$];
  logic [23:0] exp_c[8];
  longint      lat;

  function automatic logic [23:0] pattern(int i, int s);
    if (s >= AW) return 24'h0;
    return ((i / (1 << s)) % 2 == 1) ? ON : 24'h0;
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit s, input int sl, input bit rd, input bit lt);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit ev;
      ev = m_stream[k];
      chk($sformatf("valid%0d", k), longint'(valid_o[k]), longint'(ev));
      chk($sformatf("busy%0d", k), longint'(busy_o[k]),
          longint'(m_stream[k] || m_wait[k] || (m_pulse_at[k] >= cyc)));
      chk($sformatf("disp%0d", k), longint'(disp_o[k]), longint'(m_pulse_at[k] == cyc));
      chk($sformatf("first%0d", k), longint'(first_o[k]), longint'(ev && m_idx[k] == 0));
      chk($sformatf("last%0d", k), longint'(last_o[k]), longint'(ev && m_idx[k] == N - 1));
      if (ev) begin
        chk($sformatf("index%0d", k), longint'(idx_o[k]), longint'(m_idx[k]));
        chk($sformatf("color%0d", k), longint'(color_o[k]), longint'(pattern(m_idx[k], m_sel[k])));
      end
      if (prev_rst) begin
        chk($sformatf("rst_color%0d", k), longint'(color_o[k]), 0);
        chk($sformatf("rst_index%0d", k), longint'(idx_o[k]), 0);
        chk($sformatf("rst_valid%0d", k), longint'(valid_o[k]), 0);
        chk($sformatf("rst_busy%0d", k), longint'(busy_o[k]), 0);
        chk($sformatf("rst_disp%0d", k), longint'(disp_o[k]), 0);
      end
      if (disp_o[k]) begin
        disp_cnt[k]++;
        last_disp[k] = cyc;
      end
    end
    if (cap_en && valid_o[0] && rd) begin
      cap_col.push_back(color_o[0]);
      cap_idx.push_back(int'(idx_o[0]));
    end
    rst = r; start = s; sel = SW'(sl); ready = rd; latch = lt;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_stream[k] = 0; m_wait[k] = 0; m_idx[k] = 0; m_sel[k] = 0; m_pulse_at[k] = -1;
      end else if (s) begin
        m_stream[k] = 1; m_wait[k] = 0; m_idx[k] = 0; m_sel[k] = sl; m_pulse_at[k] = -1;
      end else if (m_stream[k] && rd) begin
        if (m_idx[k] == N - 1) begin
          m_stream[k] = 0; m_wait[k] = 1; m_idx[k] = 0;
        end else begin
          m_idx[k]++;
        end
      end else if (m_wait[k] && lt) begin
        m_wait[k] = 0;
        m_pulse_at[k] = cyc + 1 + settle[k];
      end
    end
    prev_rst = r;
    cyc++;
  endtask

  task automatic run(input int n, input bit rd);
    repeat (n) step(0, 0, 0, rd, 0);
  endtask

  task automatic check_frame(string nm);
    chk({nm, "_beats"}, cap_col.size(), 8);
    for (int i = 0; i < 8 && i < cap_col.size(); i++) begin
      chk($sformatf("%s_color%0d", nm, i), longint'(cap_col[i]), longint'(exp_c[i]));
      chk($sformatf("%s_index%0d", nm, i), cap_idx[i], i);
    end
  endtask

  task automatic clear_counts();
    cap_col.delete(); cap_idx.delete();
    disp_cnt = '{0, 0};
    last_disp = '{-1, -1};
  endtask

  initial begin
    rst = 1; start = 0; sel = '0; ready = 0; latch = 0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    run(2, 1);

    // Basic frame, sel=1
    clear_counts();
    step(0, 1, 1, 1, 0);
    run(9, 1);
    lat = cyc;
    step(0, 0, 0, 0, 1);
    run(8, 0);
    exp_c = '{24'h0, 24'h0, ON, ON, 24'h0, 24'h0, ON, ON};
    check_frame("basic");
    chk("basic_pulse_s3", last_disp[0], lat + 4);
    chk("basic_pulse_s0", last_disp[1], lat + 1);
    chk("basic_pulse_count", disp_cnt[0], 1);

    // Backpressure, sel=0, ready 1,0,0 repeating
    clear_counts();
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 0, (i % 3) == 0, 0);
    step(0, 0, 0, 0, 1);
    run(8, 0);
    exp_c = '{24'h0, ON, 24'h0, ON, 24'h0, ON, 24'h0, ON};
    check_frame("bp");
    chk("bp_pulse_count", disp_cnt[0], 1);

    // Restart mid-stream with sel=2
    clear_counts();
    step(0, 1, 0, 1, 0);
    run(4, 1);
    step(0, 1, 2, 0, 0);
    cap_col.delete(); cap_idx.delete();
    @(posedge clk); #1;
    chk("restart_first", longint'(first_o[0]), 1);
    chk("restart_index", longint'(idx_o[0]), 0);
    run(9, 1);
    step(0, 0, 0, 0, 1);
    run(8, 0);
    exp_c = '{24'h0, 24'h0, 24'h0, 24'h0, ON, ON, ON, ON};
    check_frame("restart");
    chk("restart_pulse_count", disp_cnt[0], 1);

    // Out-of-range select
    clear_counts();
    step(0, 1, 3, 1, 0);
    run(9, 1);
    step(0, 0, 0, 0, 1);
    run(8, 0);
    exp_c = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    check_frame("oor");
    chk("oor_pulse_count", disp_cnt[0], 1);

    // Stray latches, then start coincident with latch
    clear_counts();
    step(0, 0, 0, 0, 1);
    step(0, 1, 1, 1, 0);
    repeat (3) step(0, 0, 0, 1, 1);
    run(6, 1);
    step(0, 1, 1, 1, 1);
    @(posedge clk); #1;
    chk("coincident_valid", longint'(valid_o[0]), 1);
    run(12, 0);
    chk("stray_pulse_s3", disp_cnt[0], 0);
    chk("stray_pulse_s0", disp_cnt[1], 0);

    // Reset mid-settle
    clear_counts();
    step(0, 1, 2, 1, 0);
    run(9, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    run(8, 0);
    chk("rst_settle_pulse", disp_cnt[0], 0);

    // Random traffic
    cap_en = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(199) == 0, $urandom_range(39) == 0, int'($urandom_range(3)),
           $urandom_range(1) == 1, $urandom_range(5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
